// File: rtl/video_mem_arbiter.sv
// Slot-based DRAM owner arbiter: video fetch, CPU accesses and (optionally) refresh.
// Refresh generation is built only when VIDEO_MEM_ARB_REFRESH_EN is defined.
module video_mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cend,
    input  logic        video_go,
    input  logic [1:0]  video_bw,
    input  logic [20:0] video_addr,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [20:0] cpu_addr,
    input  logic [15:0] cpu_wrdata,
    output logic [20:0] dram_addr,
    output logic        dram_rnw,
    output logic [15:0] dram_wrdata,
    output logic        dram_req,
    output logic        dram_rfsh,
    output logic        video_next,
    output logic        video_strobe,
    output logic        cpu_next,
    output logic        cpu_strobe
);

    // state   | meaning
    // S_IDLE  | slot unused, no DRAM access
    // S_VIDEO | slot owned by video fetch (read)
    // S_CPU   | slot owned by CPU read/write
    // S_RFSH  | slot used for refresh (refresh builds only)
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_VIDEO = 2'd1,
        S_CPU   = 2'd2
`ifdef VIDEO_MEM_ARB_REFRESH_EN
        , S_RFSH = 2'd3
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  slot_q, slot_d;
    logic [20:0] addr_q, addr_d;
    logic        rnw_q, rnw_d;
    logic [15:0] wrdata_q, wrdata_d;
    logic        req_q, req_d;
    logic        vnext_q, vnext_d;
    logic        vstb_q, vstb_d;
    logic        cnext_q, cnext_d;
    logic        cstb_q, cstb_d;
    logic [2:0]  slot_n;
    logic        video_slot;
`ifdef VIDEO_MEM_ARB_REFRESH_EN
    logic [5:0]  rcnt_q, rcnt_d;
    logic        pend_q, pend_d;
    logic        rfsh_q, rfsh_d;
`endif

    // The decision at cend looks at the slot about to start, not the one ending.
    always_comb begin
        slot_n = slot_q + 3'd1;
        case (video_bw)
            2'b00:   video_slot = video_go && (slot_n == 3'd0);
            2'b01:   video_slot = video_go && (slot_n[1:0] == 2'd0);
            2'b10:   video_slot = video_go && !slot_n[0];
            default: video_slot = video_go;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        addr_d   = addr_q;
        rnw_d    = rnw_q;
        wrdata_d = wrdata_q;
        req_d    = req_q;
        vnext_d  = 1'b0;
        vstb_d   = 1'b0;
        cnext_d  = 1'b0;
        cstb_d   = 1'b0;
`ifdef VIDEO_MEM_ARB_REFRESH_EN
        rcnt_d   = rcnt_q;
        pend_d   = pend_q;
        rfsh_d   = rfsh_q;
`endif
        if (cend) begin
            slot_d  = slot_n;
            vstb_d  = (state_q == S_VIDEO);
            cstb_d  = (state_q == S_CPU);
            state_d = S_IDLE;
            req_d   = 1'b0;
`ifdef VIDEO_MEM_ARB_REFRESH_EN
            rfsh_d  = 1'b0;
            rcnt_d  = rcnt_q + 6'd1;
`endif
            if (video_slot) begin
                state_d = S_VIDEO;
                addr_d  = video_addr;
                rnw_d   = 1'b1;
                req_d   = 1'b1;
                vnext_d = 1'b1;
            end
`ifdef VIDEO_MEM_ARB_REFRESH_EN
            else if (pend_q) begin
                state_d = S_RFSH;
                rfsh_d  = 1'b1;
                pend_d  = 1'b0;
            end
`endif
            else if (cpu_req) begin
                state_d  = S_CPU;
                addr_d   = cpu_addr;
                rnw_d    = cpu_rnw;
                wrdata_d = cpu_wrdata;
                req_d    = 1'b1;
                cnext_d  = 1'b1;
            end
`ifdef VIDEO_MEM_ARB_REFRESH_EN
            // A wrap while still pending just leaves one refresh owed.
            if (rcnt_q == 6'd63) pend_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            slot_q   <= 3'd0;
            addr_q   <= 21'd0;
            rnw_q    <= 1'b1;
            wrdata_q <= 16'd0;
            req_q    <= 1'b0;
            vnext_q  <= 1'b0;
            vstb_q   <= 1'b0;
            cnext_q  <= 1'b0;
            cstb_q   <= 1'b0;
`ifdef VIDEO_MEM_ARB_REFRESH_EN
            rcnt_q   <= 6'd0;
            pend_q   <= 1'b0;
            rfsh_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            addr_q   <= addr_d;
            rnw_q    <= rnw_d;
            wrdata_q <= wrdata_d;
            req_q    <= req_d;
            vnext_q  <= vnext_d;
            vstb_q   <= vstb_d;
            cnext_q  <= cnext_d;
            cstb_q   <= cstb_d;
`ifdef VIDEO_MEM_ARB_REFRESH_EN
            rcnt_q   <= rcnt_d;
            pend_q   <= pend_d;
            rfsh_q   <= rfsh_d;
`endif
        end
    end

    assign dram_addr    = addr_q;
    assign dram_rnw     = rnw_q;
    assign dram_wrdata  = wrdata_q;
    assign dram_req     = req_q;
    assign video_next   = vnext_q;
    assign video_strobe = vstb_q;
    assign cpu_next     = cnext_q;
    assign cpu_strobe   = cstb_q;
`ifdef VIDEO_MEM_ARB_REFRESH_EN
    assign dram_rfsh    = rfsh_q;
`else
    assign dram_rfsh    = 1'b0;
`endif

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Self-checking bench for video_mem_arbiter: vector table, directed corner sequences
// and randomized traffic against a slot-arithmetic reference model.
module tb_video_mem_arbiter;

`ifdef VIDEO_MEM_ARB_REFRESH_EN
    localparam bit REFRESH = 1'b1;
`else
    localparam bit REFRESH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cend = 1'b0;
    logic        video_go = 1'b0;
    logic [1:0]  video_bw = 2'b00;
    logic [20:0] video_addr = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_rnw = 1'b1;
    logic [20:0] cpu_addr = '0;
    logic [15:0] cpu_wrdata = '0;
    logic [20:0] dram_addr;
    logic        dram_rnw;
    logic [15:0] dram_wrdata;
    logic        dram_req;
    logic        dram_rfsh;
    logic        video_next;
    logic        video_strobe;
    logic        cpu_next;
    logic        cpu_strobe;

    video_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n), .cend(cend),
        .video_go(video_go), .video_bw(video_bw), .video_addr(video_addr),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata),
        .dram_addr(dram_addr), .dram_rnw(dram_rnw), .dram_wrdata(dram_wrdata),
        .dram_req(dram_req), .dram_rfsh(dram_rfsh),
        .video_next(video_next), .video_strobe(video_strobe),
        .cpu_next(cpu_next), .cpu_strobe(cpu_strobe)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ph = 0;

    // Reference model: owner per slot from cend count since reset.
    int          m_cends;
    bit          m_pend;
    int          m_owner;   // 0 idle, 1 video, 2 cpu, 3 refresh
    logic [20:0] e_addr;
    logic        e_rnw;
    logic [15:0] e_wd;
    logic        e_req, e_rfsh, e_vn, e_vs, e_cn, e_cs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int period;
        bit vslot;
        if (!rst_n) begin
            m_cends = 0; m_pend = 0; m_owner = 0;
            e_addr = '0; e_rnw = 1'b1; e_wd = '0;
            e_req = 0; e_rfsh = 0; e_vn = 0; e_vs = 0; e_cn = 0; e_cs = 0;
        end else begin
            e_vn = 0; e_vs = 0; e_cn = 0; e_cs = 0;
            if (cend) begin
                e_vs = (m_owner == 1);
                e_cs = (m_owner == 2);
                m_cends++;
                period = 8 >> int'(video_bw);
                vslot = video_go && ((m_cends % period) == 0);
                if (vslot) m_owner = 1;
                else if (REFRESH && m_pend) begin m_owner = 3; m_pend = 0; end
                else if (cpu_req) m_owner = 2;
                else m_owner = 0;
                if (REFRESH && (m_cends % 64) == 0) m_pend = 1;
                e_req = (m_owner == 1) || (m_owner == 2);
                e_rfsh = (m_owner == 3);
                if (m_owner == 1) begin
                    e_addr = video_addr; e_rnw = 1'b1; e_vn = 1;
                end else if (m_owner == 2) begin
                    e_addr = cpu_addr; e_rnw = cpu_rnw; e_wd = cpu_wrdata; e_cn = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("dram_addr", 32'(dram_addr), 32'(e_addr));
        chk("dram_rnw", 32'(dram_rnw), 32'(e_rnw));
        chk("dram_wrdata", 32'(dram_wrdata), 32'(e_wd));
        chk("dram_req", 32'(dram_req), 32'(e_req));
        chk("dram_rfsh", 32'(dram_rfsh), 32'(e_rfsh));
        chk("video_next", 32'(video_next), 32'(e_vn));
        chk("video_strobe", 32'(video_strobe), 32'(e_vs));
        chk("cpu_next", 32'(cpu_next), 32'(e_cn));
        chk("cpu_strobe", 32'(cpu_strobe), 32'(e_cs));
    endtask

    task automatic step();
        @(negedge clk);
        cend = (ph == 3);
        ph = (ph + 1) % 4;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Advance to just after the next cend edge (at most 4 clocks).
    task automatic run_cycle();
        for (int i = 0; i < 4; i++) begin
            step();
            if (cend) break;
        end
    endtask

    typedef struct {
        logic       vg;
        logic [1:0] bw;
        logic       creq;
        logic       exp_vn;
        logic       exp_cn;
        logic       exp_req;
    } vec_t;

    vec_t vec[12];

    initial begin
        int cn_cnt, vn_cnt, cs_cnt, vs_cnt, first_v, rf_cnt, first_rf;

        #200_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cn_cnt, vn_cnt, cs_cnt, vs_cnt, first_v, rf_cnt, first_rf;

        // Decisions n = 1..12 after reset.
        vec[0]  = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[1]  = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[2]  = '{1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[3]  = '{1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1};
        vec[4]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[5]  = '{1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1};
        vec[6]  = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[7]  = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1};
        vec[8]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[9]  = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[10] = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[11] = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("reset_addr", 32'(dram_addr), 32'h0);
        chk("reset_rnw", 32'(dram_rnw), 32'h1);
        chk("reset_req", 32'(dram_req), 32'h0);
        rst_n = 1'b1;

        for (int r = 0; r < 12; r++) begin
            video_go = vec[r].vg; video_bw = vec[r].bw; cpu_req = vec[r].creq;
            cpu_rnw = 1'($urandom); cpu_addr = 21'($urandom); cpu_wrdata = 16'($urandom);
            video_addr = 21'($urandom);
            for (int k = 0; k < 4; k++) step();
            chk($sformatf("vec%0d_video_next", r), 32'(video_next), 32'(vec[r].exp_vn));
            chk($sformatf("vec%0d_cpu_next", r), 32'(cpu_next), 32'(vec[r].exp_cn));
            chk($sformatf("vec%0d_dram_req", r), 32'(dram_req), 32'(vec[r].exp_req));
        end

        // Single CPU write on an idle bus.
        video_go = 1'b0; cpu_req = 1'b0;
        run_cycle();
        run_cycle();
        cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 21'h1ABCD; cpu_wrdata = 16'h5A5A;
        run_cycle();
        chk("wr_addr", 32'(dram_addr), 32'h1ABCD);
        chk("wr_rnw", 32'(dram_rnw), 32'h0);
        chk("wr_data", 32'(dram_wrdata), 32'h5A5A);
        chk("wr_next", 32'(cpu_next), 32'h1);
        cpu_req = 1'b0;
        cs_cnt = 0;
        for (int k = 0; k < 3; k++) begin step(); cs_cnt += int'(cpu_strobe); end
        chk("wr_strobe_early", 32'(cs_cnt), 32'h0);
        step();
        chk("wr_strobe_4clk", 32'(cpu_strobe), 32'h1);

        // bw=00 with CPU held: 14 CPU grants and 2 video grants per 16 slots.
        video_go = 1'b1; video_bw = 2'b00; cpu_req = 1'b1; cpu_rnw = 1'b1;
        cn_cnt = 0; vn_cnt = 0; cs_cnt = 0;
        for (int i = 1; i <= 17; i++) begin
            run_cycle();
            if (i <= 16) begin cn_cnt += int'(cpu_next); vn_cnt += int'(video_next); end
            if (i >= 2) cs_cnt += int'(cpu_strobe);
        end
        chk("bw00_cpu_next", 32'(cn_cnt), 32'd14);
        chk("bw00_video_next", 32'(vn_cnt), 32'd2);
        chk("bw00_cpu_strobe", 32'(cs_cnt), 32'd14);

        // bw=11 starves the CPU until video_go drops.
        video_bw = 2'b11;
        cn_cnt = 0; vn_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            run_cycle();
            cn_cnt += int'(cpu_next); vn_cnt += int'(video_next);
        end
        chk("bw11_cpu_next", 32'(cn_cnt), 32'd0);
        chk("bw11_video_next", 32'(vn_cnt), 32'd8);
        video_go = 1'b0;
        run_cycle();
        chk("bw11_drop_cpu_next", 32'(cpu_next), 32'h1);
        chk("bw11_drop_vstrobe", 32'(video_strobe), 32'h1);

        // Reset for one clock in the middle of a VIDEO cycle.
        video_go = 1'b1; cpu_req = 1'b0;
        run_cycle();
        run_cycle();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_req", 32'(dram_req), 32'h0);
        chk("midrst_addr", 32'(dram_addr), 32'h0);
        chk("midrst_rnw", 32'(dram_rnw), 32'h1);
        chk("midrst_wrdata", 32'(dram_wrdata), 32'h0);
        video_bw = 2'b00;
        vs_cnt = 0; first_v = 0;
        for (int i = 1; i <= 8; i++) begin
            run_cycle();
            if (i == 1) vs_cnt = int'(video_strobe);
            if (video_next && first_v == 0) first_v = i;
        end
        chk("midrst_no_vstrobe", 32'(vs_cnt), 32'h0);
        chk("midrst_first_video_slot", 32'(first_v), 32'd8);

        // bw=01: drop video_go during slot 1; slot 0 completes, slot 4 is not video.
        video_bw = 2'b01;
        for (int i = 0; i < 8 && (m_cends % 8) != 7; i++) run_cycle();
        run_cycle();
        chk("drop_slot0_vnext", 32'(video_next), 32'h1);
        run_cycle();
        chk("drop_slot0_vstrobe", 32'(video_strobe), 32'h1);
        video_go = 1'b0;
        run_cycle();
        run_cycle();
        run_cycle();
        chk("drop_slot4_vnext", 32'(video_next), 32'h0);
        chk("drop_slot4_req", 32'(dram_req), 32'h0);

`ifdef VIDEO_MEM_ARB_REFRESH_EN
        // One refresh per 64 cycles with CPU held and video off.
        video_go = 1'b0; cpu_req = 1'b1;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        rf_cnt = 0; first_rf = 0;
        for (int i = 1; i <= 129; i++) begin
            run_cycle();
            if (dram_rfsh) begin
                rf_cnt++;
                if (first_rf == 0) first_rf = i;
            end
        end
        chk("rfsh_count", 32'(rf_cnt), 32'd2);
        chk("rfsh_first_slot", 32'(first_rf), 32'd65);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 3) == 0) video_go = 1'($urandom);
            if ($urandom_range(0, 15) == 0) video_bw = 2'($urandom);
            cpu_req = ($urandom_range(0, 2) != 0);
            cpu_rnw = 1'($urandom);
            cpu_addr = 21'($urandom);
            cpu_wrdata = 16'($urandom);
            video_addr = 21'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
